// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO for the EX stage.
// Optional MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
// Ports:
//   CLK, RST (async, active-low)
//   Start/Op/A/B: issue; Flush: abort in flight
//   HI/LO: result registers; Busy: EX stall source
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy
);

  localparam int W2   = 2 * WIDTH;
  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int NMUL = WIDTH / MUL_STEP;
  localparam int PW   = WIDTH + MUL_STEP;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic             div0_q, div0_d;
  logic             isdiv_q, isdiv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_MADD_EN
  logic             acc_q, acc_d;
  logic             sub_q, sub_d;
  logic             dec_acc, dec_sub;
`endif

  logic dec_mul, dec_div, dec_mthi, dec_mtlo, dec_sgn;

  always_comb begin
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    dec_mthi = 1'b0;
    dec_mtlo = 1'b0;
    dec_sgn  = 1'b0;
`ifdef MULDIV_MADD_EN
    dec_acc  = 1'b0;
    dec_sub  = 1'b0;
`endif
    case (Op)
      4'd0: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      4'd1: dec_mul = 1'b1;
      4'd2: begin dec_div = 1'b1; dec_sgn = 1'b1; end
      4'd3: dec_div = 1'b1;
      4'd4: dec_mthi = 1'b1;
      4'd5: dec_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      4'd6: begin
        dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1;
      end
      4'd7: begin dec_mul = 1'b1; dec_acc = 1'b1; end
      4'd8: begin
        dec_mul = 1'b1; dec_sgn = 1'b1;
        dec_acc = 1'b1; dec_sub = 1'b1;
      end
      4'd9: begin
        dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // operand magnitudes; signed ops record the result signs
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = dec_sgn & A[WIDTH-1];
  assign b_neg = dec_sgn & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // multiply step: prod_q = {partial, multiplier}, shift right by MUL_STEP
  logic [PW-1:0] pp, msum;
  logic [W2-1:0] mul_nxt;

  assign pp      = PW'(opnd_q) * PW'(prod_q[MUL_STEP-1:0]);
  assign msum    = PW'(prod_q[W2-1:WIDTH]) + pp;
  assign mul_nxt = {msum, prod_q[WIDTH-1:MUL_STEP]};

  // restoring divide step: prod_q = {remainder, dividend/quotient}
  logic [WIDTH:0] dshift, ddiff;
  logic [W2-1:0]  div_nxt;

  assign dshift  = prod_q[W2-1:WIDTH-1];
  assign ddiff   = dshift - {1'b0, opnd_q};
  assign div_nxt = ddiff[WIDTH]
                 ? {dshift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                 : {ddiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  // sign correction at FIX
  logic [W2-1:0]    mres, mfin;
  logic [WIDTH-1:0] quo, rem, dq, dr;

  assign mres = neg_q ? -prod_q : prod_q;
`ifdef MULDIV_MADD_EN
  logic [W2-1:0] maddend;
  assign maddend = sub_q ? -mres : mres;
  assign mfin    = acc_q ? ({hi_q, lo_q} + maddend) : mres;
`else
  assign mfin = mres;
`endif

  assign quo = prod_q[WIDTH-1:0];
  assign rem = prod_q[W2-1:WIDTH];
  // divide by zero leaves an all-ones quotient regardless of signs
  assign dq  = div0_q ? '1 : (neg_q ? -quo : quo);
  assign dr  = negr_q ? -rem : rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    isdiv_d = isdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (dec_mthi) hi_d = A;
            if (dec_mtlo) lo_d = A;
            if (dec_mul) begin
              state_d = S_MUL;
              cnt_d   = '0;
              prod_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d  = a_mag;
              neg_d   = a_neg ^ b_neg;
              isdiv_d = 1'b0;
`ifdef MULDIV_MADD_EN
              acc_d   = dec_acc;
              sub_d   = dec_sub;
`endif
            end
            if (dec_div) begin
              state_d = S_DIV;
              cnt_d   = '0;
              prod_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d  = b_mag;
              neg_d   = a_neg ^ b_neg;
              negr_d  = a_neg;
              div0_d  = (B == '0);
              isdiv_d = 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_d = mul_nxt;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(NMUL - 1)) state_d = S_FIX;
        end
        S_DIV: begin
          prod_d = div_nxt;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          if (isdiv_q) begin
            hi_d = dr;
            lo_d = dq;
          end else begin
            {hi_d, lo_d} = mfin;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      isdiv_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      isdiv_q <= isdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at MUL_STEP 1, 2 and 4.
// Compile with +define+MULDIV_MADD_EN to cover the accumulate ops.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [3:0]  Op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] hi1, lo1, hi2, lo2, hi4, lo4;
  logic        bz1, bz2, bz4;
  int          n_chk = 0;
  int          n_err = 0;
  int          c1, c2, c4;

  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u1 (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .A(A), .B(B), .Flush(Flush),
    .HI(hi1), .LO(lo1), .Busy(bz1)
  );

  muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) u2 (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .A(A), .B(B), .Flush(Flush),
    .HI(hi2), .LO(lo2), .Busy(bz2)
  );

  muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u4 (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .A(A), .B(B), .Flush(Flush),
    .HI(hi4), .LO(lo4), .Busy(bz4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns Busy cycle counts per instance
  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int n1, output int n2,
                        output int n4);
    Op = op; A = a; B = b; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    n1 = 0; n2 = 0; n4 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(bz1 || bz2 || bz4)) break;
      n1 += int'(bz1);
      n2 += int'(bz2);
      n4 += int'(bz4);
      @(negedge CLK);
    end
    if (bz1 || bz2 || bz4) chk("timeout", 1, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_hi", hi1, 0);
    chk("rst_lo", lo1, 0);
    chk("rst_busy", bz1, 0);
    RST = 1'b1;
    @(negedge CLK);

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, c1, c2, c4);
    chk("mult_busy", c1, 33);
    chk("mult_hi", hi1, 32'hFFFFFFFF);
    chk("mult_lo", lo1, 32'hFFFFFFFA);
    chk("mult_s4", {hi4, lo4}, 64'hFFFFFFFF_FFFFFFFA);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, c1, c2, c4);
    chk("multu_busy1", c1, 33);
    chk("multu_busy2", c2, 17);
    chk("multu_busy4", c4, 9);
    chk("multu_s1", {hi1, lo1}, 64'hFFFFFFFE_00000001);
    chk("multu_s2", {hi2, lo2}, 64'hFFFFFFFE_00000001);
    chk("multu_s4", {hi4, lo4}, 64'hFFFFFFFE_00000001);

    run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, c1, c2, c4);
    chk("mult_max", {hi1, lo1}, 64'h3FFFFFFF_00000001);
    chk("mult_max_s2", {hi2, lo2}, 64'h3FFFFFFF_00000001);

    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, c1, c2, c4);
    chk("mult_m1m1", {hi1, lo1}, 64'h00000000_00000001);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, c1, c2, c4);
    chk("div_busy", c1, 33);
    chk("div_lo", lo1, 32'hFFFFFFFD);
    chk("div_hi", hi1, 32'hFFFFFFFF);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, c1, c2, c4);
    chk("div_ovf_lo", lo1, 32'h80000000);
    chk("div_ovf_hi", hi1, 32'h0);

    run_op(OP_DIVU, 32'd5, 32'd0, c1, c2, c4);
    chk("div0_busy", c1, 33);
    chk("div0_lo", lo1, 32'hFFFFFFFF);
    chk("div0_hi", hi1, 32'd5);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, c1, c2, c4);
    chk("sdiv0", {hi1, lo1}, 64'hFFFFFFF9_FFFFFFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, c1, c2, c4);
    chk("div_7_m2", {hi1, lo1}, 64'h00000001_FFFFFFFD);

    run_op(OP_DIVU, 32'd100, 32'd7, c1, c2, c4);
    chk("divu_100_7", {hi1, lo1}, 64'h00000002_0000000E);

    run_op(OP_MTHI, 32'h1234, 32'd0, c1, c2, c4);
    chk("mthi_busy", c1, 0);
    chk("mthi_hi", hi1, 32'h1234);
    run_op(OP_MTLO, 32'h55, 32'd0, c1, c2, c4);
    chk("mtlo_lo", {hi1, lo1}, 64'h00001234_00000055);

    // MULT 2*3, a Start while busy, then Flush on the 5th Busy cycle
    Op = OP_MULT; A = 32'd2; B = 32'd3; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    Op = OP_MTLO; A = 32'h9999; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("flush_pre_busy", bz1, 1);
    Flush = 1'b1;
    @(posedge CLK);
    #1;
    chk("flush_busy", {bz1, bz2, bz4}, 0);
    @(negedge CLK);
    Flush = 1'b0;
    chk("flush_hilo", {hi1, lo1}, 64'h00001234_00000055);

    Op = OP_MTHI; A = 32'hBEEF; Start = 1'b1; Flush = 1'b1;
    @(negedge CLK);
    Start = 1'b0; Flush = 1'b0;
    @(negedge CLK);
    chk("flush_start_hi", hi1, 32'h1234);
    chk("flush_start_busy", bz1, 0);

`ifdef MULDIV_MADD_EN
    run_op(OP_MTLO, 32'd10, 32'd0, c1, c2, c4);
    run_op(OP_MTHI, 32'd0, 32'd0, c1, c2, c4);
    run_op(OP_MADD, 32'd4, 32'd5, c1, c2, c4);
    chk("madd_busy", c1, 33);
    chk("madd", {hi1, lo1}, 64'h00000000_0000001E);
    chk("madd_s4", {hi4, lo4}, 64'h00000000_0000001E);
    run_op(OP_MSUBU, 32'd1, 32'd31, c1, c2, c4);
    chk("msubu", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFF);
    chk("msubu_s2", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFFF);
`else
    run_op(4'd6, 32'd4, 32'd5, c1, c2, c4);
    chk("op6_busy", c1, 0);
    chk("op6_hilo", {hi1, lo1}, 64'h00001234_00000055);
    run_op(4'd15, 32'd4, 32'd5, c1, c2, c4);
    chk("op15_busy", c1, 0);
    chk("op15_hilo", {hi1, lo1}, 64'h00001234_00000055);
`endif

    // reset in the middle of an operation
    Op = OP_MULT; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_busy", bz1, 0);
    chk("midrst_hilo", {hi1, lo1}, 64'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_idle", bz1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
